cam_stats_roi: RTL and testbench
================================

Name: cam_stats_roi

Overview:
- Per-frame statistics engine for camera/VGA pixel streams; next generation of the single-channel frame averager.
- Generalised to CH colour channels, a programmable rectangular region of interest (ROI), per-channel average/max/min, and programmable frame decimation.
- Uses a multi-cycle sequential divider with a result-valid pulse.
- Sits beside the VGA timing path; results feed auto-exposure and white-balance logic.

Parameters:
CH, 3, number of colour channels packed in PIXEL (channel 0 in LSBs)
PIX_W, 8, bits per channel
CNT_W, 20, pixel-counter width; ACC_W = PIX_W+CNT_W accumulator width
COORD_W, 11, width of pixel coordinates and ROI bounds
FRAME_DIV, 30, statistics published once every FRAME_DIV frames (>=1)

Ports:
VGA_CLK  in  1  pixel clock
RST_N  in  1  asynchronous active-low reset
V_SYNC  in  1  active-low vertical sync, sampled synchronously
PIX_VALID  in  1  pixel qualifier
PIX_X, PIX_Y  in  COORD_W each  coordinates of current pixel
PIXEL  in  CH*PIX_W  packed pixel
ROI_X0, ROI_X1, ROI_Y0, ROI_Y1  in  COORD_W each  inclusive ROI bounds, sampled at frame start
AVG  out  CH*PIX_W  per-channel floor average
MAX  out  CH*PIX_W  per-channel maximum
MIN  out  CH*PIX_W  per-channel minimum
STATS_VALID  out  1  one-cycle pulse when AVG/MAX/MIN update
BUSY  out  1  divider running
OVERRUN  out  1  sticky: a publish frame arrived while BUSY

Behaviour:
- Reset:
  - RST_N is asynchronous, active-low; clock is VGA_CLK.
  - On reset: all outputs 0; accumulators, counter, max 0; min all-ones; frame counter 0; FSM in IDLE.
- V_SYNC is registered once (vs_q).
- Frame end T0: the rising VGA_CLK edge where V_SYNC=0 and vs_q=1.
  - No other asynchronous V_SYNC behaviour.
- Frame start: the edge where V_SYNC=1 and vs_q=0.
  - ROI bounds are latched here; changes mid-frame are ignored.
- Accumulate:
  - Condition: V_SYNC=1 and PIX_VALID=1 and ROI_X0<=PIX_X<=ROI_X1 and ROI_Y0<=PIX_Y<=ROI_Y1.
  - Action: sum[c]+=pixel[c]; max/min update; count+=1.
  - Pixels during V_SYNC=0 are ignored.
  - X0>X1 or Y0>Y1 gives an empty ROI (count 0).
- Saturation: when count reaches 2^CNT_W-1, sum, count, max and min freeze for the rest of the frame. The sum never overflows.
- At T0:
  - Snapshot sum/count/max/min.
  - Clear the accumulators (min to all-ones) in the same edge.
  - A pixel presented on the T0 edge is not accumulated.
- Frame counter: increments at each T0.
  - Publish frame: frame_cnt==FRAME_DIV-1; the counter then wraps to 0.
  - FRAME_DIV=1 publishes every frame.
- FSM states IDLE, DIV, DONE:
  - IDLE -> DIV at a publish-frame T0 with BUSY=0.
  - DIV runs a restoring divider, all channels in parallel, one quotient bit per cycle, for ACC_W cycles, then -> DONE.
  - DONE (1 cycle): AVG, MAX, MIN register; STATS_VALID=1; -> IDLE.
- Latency: STATS_VALID is high exactly on edge T0+ACC_W+1. BUSY is high from T0+1 through T0+ACC_W+1 inclusive.
- Division: AVG = floor(sum/count), truncated to PIX_W bits; the result always fits.
- count==0: AVG=MAX=MIN=0, same latency and pulse.
- Publish T0 while BUSY: that frame's snapshot is discarded and OVERRUN sets (sticky until reset). The running division completes normally. The frame counter still advances.
- Outputs hold their value between pulses.
- Reset mid-DIV: outputs 0, no STATS_VALID pulse, FSM IDLE.

Test Plan:
- FRAME_DIV=1, ROI full, one 100-pixel frame of (200,200,200), then V_SYNC low -> STATS_VALID single pulse at T0+29 (ACC_W=28); AVG=MAX=MIN=200 all channels.
- 100 pixels with ch0=i, ch1=50, ch2=255-i (i=0..99) -> AVG=(49,50,205), MAX=(99,50,255), MIN=(0,50,156).
- 16x16 frame, ROI x=4..7, y=2..3, value 100 inside and 0 outside -> AVG=100, MIN=100, MAX=100. Changing the ROI mid-frame has no effect until the next frame.
- FRAME_DIV=30, 30 frames with frame k's pixels all =k -> no pulse for frames 1-29; pulse after frame 30 with AVG=30.
- Frame with no PIX_VALID, then separately ROI_X0>ROI_X1 -> pulse with AVG=MAX=MIN=0.
- FRAME_DIV=1 with frames of 5 pixels (shorter than ACC_W) -> OVERRUN=1, first result still delivered. Separately, RST_N low mid-DIV -> outputs 0, no pulse, BUSY=0.

Source files
------------

// File: rtl/cam_stats_roi.sv
// Per-frame ROI statistics engine: per-channel floor average, max and min of the pixels
// inside a rectangular region, published once every FRAME_DIV frames via a sequential divider.
//   state | meaning
//   IDLE  | waiting for a publish-frame end
//   DIV   | restoring divide of the snapshot sums, one quotient bit per cycle
//   DONE  | results registered, STATS_VALID high for this cycle
module cam_stats_roi #(
  parameter int CH        = 3,
  parameter int PIX_W     = 8,
  parameter int CNT_W     = 20,
  parameter int COORD_W   = 11,
  parameter int FRAME_DIV = 30
) (
  input  logic                  VGA_CLK,
  input  logic                  RST_N,
  input  logic                  V_SYNC,
  input  logic                  PIX_VALID,
  input  logic [COORD_W-1:0]    PIX_X,
  input  logic [COORD_W-1:0]    PIX_Y,
  input  logic [CH*PIX_W-1:0]   PIXEL,
  input  logic [COORD_W-1:0]    ROI_X0,
  input  logic [COORD_W-1:0]    ROI_X1,
  input  logic [COORD_W-1:0]    ROI_Y0,
  input  logic [COORD_W-1:0]    ROI_Y1,
  output logic [CH*PIX_W-1:0]   AVG,
  output logic [CH*PIX_W-1:0]   MAX,
  output logic [CH*PIX_W-1:0]   MIN,
  output logic                  STATS_VALID,
  output logic                  BUSY,
  output logic                  OVERRUN
);
  localparam int ACC_W = PIX_W + CNT_W;
  localparam int FC_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int BC_W  = (ACC_W > 2) ? $clog2(ACC_W) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FRAME_DIV - 1);

  logic                          vs_q, vs_d;
  logic [COORD_W-1:0]            roi_x0_q, roi_x0_d, roi_x1_q, roi_x1_d;
  logic [COORD_W-1:0]            roi_y0_q, roi_y0_d, roi_y1_q, roi_y1_d;
  logic [CH-1:0][ACC_W-1:0]      sum_q, sum_d;
  logic [CH-1:0][PIX_W-1:0]      max_q, max_d, min_q, min_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [FC_W-1:0]               frame_cnt_q, frame_cnt_d;
  logic [1:0]                    state_q, state_d;
  logic [BC_W-1:0]               bit_cnt_q, bit_cnt_d;
  logic [CH-1:0][ACC_W-1:0]      quo_q, quo_d;
  logic [CH-1:0][CNT_W-1:0]      rem_q, rem_d;
  logic [CNT_W-1:0]              den_q, den_d;
  logic [CH-1:0][PIX_W-1:0]      snap_max_q, snap_max_d, snap_min_q, snap_min_d;
  logic [CH*PIX_W-1:0]           avg_q, avg_d, max_out_q, max_out_d, min_out_q, min_out_d;
  logic                          overrun_q, overrun_d;

  logic                          frame_start, frame_end, publish, in_roi, acc_en;
  logic [PIX_W-1:0]              pix_c;
  logic [CNT_W:0]                trial;

  always_comb begin
    vs_d        = V_SYNC;
    frame_start = V_SYNC & ~vs_q;
    frame_end   = ~V_SYNC & vs_q;

    // Bounds are taken straight from the ports on the frame-start edge so that edge's pixel
    // already sees the new region.
    roi_x0_d = frame_start ? ROI_X0 : roi_x0_q;
    roi_x1_d = frame_start ? ROI_X1 : roi_x1_q;
    roi_y0_d = frame_start ? ROI_Y0 : roi_y0_q;
    roi_y1_d = frame_start ? ROI_Y1 : roi_y1_q;

    in_roi = (PIX_X >= roi_x0_d) && (PIX_X <= roi_x1_d) &&
             (PIX_Y >= roi_y0_d) && (PIX_Y <= roi_y1_d);
    acc_en = V_SYNC && PIX_VALID && in_roi && (cnt_q != CNT_MAX);

    sum_d = sum_q;
    max_d = max_q;
    min_d = min_q;
    cnt_d = cnt_q;
    pix_c = '0;
    if (frame_end) begin
      sum_d = '0;
      max_d = '0;
      min_d = '1;
      cnt_d = '0;
    end else if (acc_en) begin
      for (int c = 0; c < CH; c++) begin
        pix_c    = PIXEL[c*PIX_W +: PIX_W];
        sum_d[c] = sum_q[c] + ACC_W'(pix_c);
        if (pix_c > max_q[c]) max_d[c] = pix_c;
        if (pix_c < min_q[c]) min_d[c] = pix_c;
      end
      cnt_d = cnt_q + CNT_W'(1);
    end

    publish     = frame_end && (frame_cnt_q == FC_LAST);
    frame_cnt_d = frame_cnt_q;
    if (frame_end) frame_cnt_d = publish ? '0 : frame_cnt_q + FC_W'(1);
    overrun_d = overrun_q | (publish & (state_q != S_IDLE));

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    den_d      = den_q;
    snap_max_d = snap_max_q;
    snap_min_d = snap_min_q;
    avg_d      = avg_q;
    max_out_d  = max_out_q;
    min_out_d  = min_out_q;
    trial      = '0;
    case (state_q)
      S_IDLE: begin
        if (publish) begin
          state_d    = S_DIV;
          bit_cnt_d  = BC_W'(ACC_W - 1);
          quo_d      = sum_q;
          rem_d      = '0;
          den_d      = cnt_q;
          snap_max_d = max_q;
          snap_min_d = min_q;
        end
      end
      S_DIV: begin
        for (int c = 0; c < CH; c++) begin
          trial = {rem_q[c], quo_q[c][ACC_W-1]};
          if (trial >= {1'b0, den_q}) begin
            rem_d[c] = CNT_W'(trial - {1'b0, den_q});
            quo_d[c] = {quo_q[c][ACC_W-2:0], 1'b1};
          end else begin
            rem_d[c] = trial[CNT_W-1:0];
            quo_d[c] = {quo_q[c][ACC_W-2:0], 1'b0};
          end
        end
        bit_cnt_d = bit_cnt_q - BC_W'(1);
        if (bit_cnt_q == '0) begin
          state_d = S_DONE;
          // An empty region divides by zero; report all-zero statistics instead.
          for (int c = 0; c < CH; c++) begin
            avg_d[c*PIX_W +: PIX_W]     = (den_q == '0) ? '0 : quo_d[c][PIX_W-1:0];
            max_out_d[c*PIX_W +: PIX_W] = (den_q == '0) ? '0 : snap_max_q[c];
            min_out_d[c*PIX_W +: PIX_W] = (den_q == '0) ? '0 : snap_min_q[c];
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      vs_q        <= 1'b0;
      roi_x0_q    <= '0;
      roi_x1_q    <= '0;
      roi_y0_q    <= '0;
      roi_y1_q    <= '0;
      sum_q       <= '0;
      max_q       <= '0;
      min_q       <= '1;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      den_q       <= '0;
      snap_max_q  <= '0;
      snap_min_q  <= '0;
      avg_q       <= '0;
      max_out_q   <= '0;
      min_out_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      vs_q        <= vs_d;
      roi_x0_q    <= roi_x0_d;
      roi_x1_q    <= roi_x1_d;
      roi_y0_q    <= roi_y0_d;
      roi_y1_q    <= roi_y1_d;
      sum_q       <= sum_d;
      max_q       <= max_d;
      min_q       <= min_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      den_q       <= den_d;
      snap_max_q  <= snap_max_d;
      snap_min_q  <= snap_min_d;
      avg_q       <= avg_d;
      max_out_q   <= max_out_d;
      min_out_q   <= min_out_d;
      overrun_q   <= overrun_d;
    end
  end

  assign AVG         = avg_q;
  assign MAX         = max_out_q;
  assign MIN         = min_out_q;
  assign STATS_VALID = (state_q == S_DONE);
  assign BUSY        = (state_q != S_IDLE);
  assign OVERRUN     = overrun_q;
endmodule

// File: tb/tb_cam_stats_roi.sv
// Bench for cam_stats_roi: two instances (publish every frame / every 30th frame) share one
// stimulus stream; a frame-level reference model queues expected results for a monitor.
module tb_cam_stats_roi;
  localparam int ACC_W   = 28;
  localparam int CNT_MAX = (1 << 20) - 1;

  logic        VGA_CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        V_SYNC = 1'b0;
  logic        PIX_VALID = 1'b0;
  logic [10:0] PIX_X = '0, PIX_Y = '0;
  logic [10:0] ROI_X0 = '0, ROI_X1 = '0, ROI_Y0 = '0, ROI_Y1 = '0;
  logic [23:0] PIXEL = '0;
  logic [23:0] avg_a, max_a, min_a, avg_b, max_b, min_b;
  logic        sv_a, busy_a, ovr_a, sv_b, busy_b, ovr_b;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          d;
    int          at;
    logic [23:0] avg;
    logic [23:0] mx;
    logic [23:0] mn;
  } exp_t;
  exp_t expq[$];

  int m_sum[3], m_max[3], m_min[3];
  int m_cnt;
  bit m_vs;
  int rx0, rx1, ry0, ry1;
  int fcnt[2], last_t0[2];
  bit m_ovr[2];

  cam_stats_roi #(.FRAME_DIV(1)) dut_a (
    .VGA_CLK(VGA_CLK), .RST_N(RST_N), .V_SYNC(V_SYNC), .PIX_VALID(PIX_VALID),
    .PIX_X(PIX_X), .PIX_Y(PIX_Y), .PIXEL(PIXEL),
    .ROI_X0(ROI_X0), .ROI_X1(ROI_X1), .ROI_Y0(ROI_Y0), .ROI_Y1(ROI_Y1),
    .AVG(avg_a), .MAX(max_a), .MIN(min_a),
    .STATS_VALID(sv_a), .BUSY(busy_a), .OVERRUN(ovr_a));

  cam_stats_roi #(.FRAME_DIV(30)) dut_b (
    .VGA_CLK(VGA_CLK), .RST_N(RST_N), .V_SYNC(V_SYNC), .PIX_VALID(PIX_VALID),
    .PIX_X(PIX_X), .PIX_Y(PIX_Y), .PIXEL(PIXEL),
    .ROI_X0(ROI_X0), .ROI_X1(ROI_X1), .ROI_Y0(ROI_Y0), .ROI_Y1(ROI_Y1),
    .AVG(avg_b), .MAX(max_b), .MIN(min_b),
    .STATS_VALID(sv_b), .BUSY(busy_b), .OVERRUN(ovr_b));

  always #5 VGA_CLK = ~VGA_CLK;
  always @(posedge VGA_CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic clear_acc();
    for (int c = 0; c < 3; c++) begin
      m_sum[c] = 0;
      m_max[c] = 0;
      m_min[c] = 255;
    end
    m_cnt = 0;
  endtask

  task automatic model_reset();
    clear_acc();
    m_vs = 1'b0;
    for (int d = 0; d < 2; d++) begin
      fcnt[d]    = 0;
      last_t0[d] = -1;
      m_ovr[d]   = 1'b0;
    end
    expq.delete();
  endtask

  task automatic push_result(input int d);
    exp_t e;
    e.d   = d;
    e.at  = cyc + ACC_W;
    e.avg = '0;
    e.mx  = '0;
    e.mn  = '0;
    if (m_cnt != 0) begin
      for (int c = 0; c < 3; c++) begin
        e.avg[c*8 +: 8] = 8'(m_sum[c] / m_cnt);
        e.mx[c*8 +: 8]  = 8'(m_max[c]);
        e.mn[c*8 +: 8]  = 8'(m_min[c]);
      end
    end
    last_t0[d] = cyc;
    expq.push_back(e);
  endtask

  // Frame-level rules applied to the inputs seen at the edge just taken.
  task automatic model_edge();
    bit fs, fe, hit;
    int px, py, v;
    fs = V_SYNC && !m_vs;
    fe = !V_SYNC && m_vs;
    if (fs) begin
      rx0 = int'(ROI_X0); rx1 = int'(ROI_X1);
      ry0 = int'(ROI_Y0); ry1 = int'(ROI_Y1);
    end
    if (fe) begin
      for (int d = 0; d < 2; d++) begin
        if (fcnt[d] == ((d == 0) ? 1 : 30) - 1) begin
          fcnt[d] = 0;
          if (last_t0[d] >= 0 && cyc <= last_t0[d] + ACC_W + 1) m_ovr[d] = 1'b1;
          else push_result(d);
        end else begin
          fcnt[d]++;
        end
      end
      clear_acc();
    end else begin
      px  = int'(PIX_X);
      py  = int'(PIX_Y);
      hit = V_SYNC && PIX_VALID && px >= rx0 && px <= rx1 && py >= ry0 && py <= ry1 &&
            m_cnt < CNT_MAX;
      if (hit) begin
        for (int c = 0; c < 3; c++) begin
          v = int'(PIXEL[c*8 +: 8]);
          m_sum[c] += v;
          if (v > m_max[c]) m_max[c] = v;
          if (v < m_min[c]) m_min[c] = v;
        end
        m_cnt++;
      end
    end
    m_vs = V_SYNC;
  endtask

  task automatic mon(input int d, input logic sv, input logic bsy, input logic ovr,
                     input logic [23:0] a, input logic [23:0] mx, input logic [23:0] mn);
    int  idx;
    bit  eb;
    idx = -1;
    eb  = (last_t0[d] >= 0) && (cyc >= last_t0[d]) && (cyc <= last_t0[d] + ACC_W);
    chk($sformatf("busy[%0d]", d), 32'(bsy), 32'(eb));
    chk($sformatf("overrun[%0d]", d), 32'(ovr), 32'(m_ovr[d]));
    for (int i = 0; i < expq.size(); i++) begin
      if (expq[i].d == d) begin
        idx = i;
        break;
      end
    end
    if (sv) begin
      if (idx < 0) begin
        chk($sformatf("unexpected_pulse[%0d]", d), 32'(1), 32'(0));
      end else begin
        chk($sformatf("pulse_cycle[%0d]", d), 32'(cyc), 32'(expq[idx].at));
        chk($sformatf("avg[%0d]", d), 32'(a), 32'(expq[idx].avg));
        chk($sformatf("max[%0d]", d), 32'(mx), 32'(expq[idx].mx));
        chk($sformatf("min[%0d]", d), 32'(mn), 32'(expq[idx].mn));
        expq.delete(idx);
      end
    end else if (idx >= 0 && expq[idx].at < cyc) begin
      chk($sformatf("missed_pulse[%0d]", d), 32'(cyc), 32'(expq[idx].at));
      expq.delete(idx);
    end
  endtask

  always @(negedge VGA_CLK) begin
    if (mon_en && RST_N) begin
      mon(0, sv_a, busy_a, ovr_a, avg_a, max_a, min_a);
      mon(1, sv_b, busy_b, ovr_b, avg_b, max_b, min_b);
    end
  end

  task automatic step(input bit vs, input bit pv, input int x, input int y,
                      input logic [23:0] pix);
    V_SYNC    = vs;
    PIX_VALID = pv;
    PIX_X     = 11'(x);
    PIX_Y     = 11'(y);
    PIXEL     = pix;
    @(posedge VGA_CLK);
    #1;
    model_edge();
  endtask

  task automatic vs_low(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(1)), 0, 0, 24'($urandom));
  endtask

  task automatic set_roi(input int x0, input int x1, input int y0, input int y1);
    ROI_X0 = 11'(x0); ROI_X1 = 11'(x1); ROI_Y0 = 11'(y0); ROI_Y1 = 11'(y1);
  endtask

  task automatic chk_outs(input string tag, input logic [23:0] a, input logic [23:0] mx,
                          input logic [23:0] mn);
    chk({tag, "_avg"}, 32'(avg_a), 32'(a));
    chk({tag, "_max"}, 32'(max_a), 32'(mx));
    chk({tag, "_min"}, 32'(min_a), 32'(mn));
  endtask

  task automatic do_reset();
    V_SYNC    = 1'b0;
    PIX_VALID = 1'b0;
    RST_N     = 1'b0;
    model_reset();
    #1;
    chk("rst_avg_a", 32'(avg_a), 0);   chk("rst_max_a", 32'(max_a), 0);
    chk("rst_min_a", 32'(min_a), 0);   chk("rst_sv_a", 32'(sv_a), 0);
    chk("rst_busy_a", 32'(busy_a), 0); chk("rst_ovr_a", 32'(ovr_a), 0);
    chk("rst_avg_b", 32'(avg_b), 0);   chk("rst_max_b", 32'(max_b), 0);
    chk("rst_min_b", 32'(min_b), 0);   chk("rst_sv_b", 32'(sv_b), 0);
    chk("rst_busy_b", 32'(busy_b), 0); chk("rst_ovr_b", 32'(ovr_b), 0);
    repeat (3) @(posedge VGA_CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    int a, b, c, d;
    #2;
    do_reset();
    mon_en = 1'b1;

    // 100 flat pixels
    set_roi(0, 2047, 0, 2047);
    step(1'b1, 1'b0, 0, 0, '0);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, i % 10, i / 10, {8'd200, 8'd200, 8'd200});
    vs_low(35);
    chk_outs("flat", 24'hC8C8C8, 24'hC8C8C8, 24'hC8C8C8);

    // ramp per channel
    step(1'b1, 1'b0, 0, 0, '0);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, i % 10, i / 10, {8'(255 - i), 8'd50, 8'(i)});
    vs_low(35);
    chk_outs("ramp", 24'hCD3231, 24'hFF3263, 24'h9C3200);

    // ROI window, bounds changed mid-frame, then the new bounds next frame
    set_roi(4, 7, 2, 3);
    for (int f = 0; f < 2; f++) begin
      step(1'b1, 1'b0, 0, 0, '0);
      for (int y = 0; y < 16; y++) begin
        if (y == 8) set_roi(0, 15, 0, 15);
        for (int x = 0; x < 16; x++)
          step(1'b1, 1'b1, x, y, (x >= 4 && x <= 7 && y >= 2 && y <= 3) ? 24'h646464 : 24'h0);
      end
      vs_low(35);
      if (f == 0) chk_outs("roi", 24'h646464, 24'h646464, 24'h646464);
      else        chk_outs("roi_next", 24'h030303, 24'h646464, 24'h000000);
    end

    // no valid pixels, then a normal frame, then an inverted ROI
    step(1'b1, 1'b0, 0, 0, '0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, i, 0, 24'($urandom));
    vs_low(35);
    chk_outs("no_valid", '0, '0, '0);
    step(1'b1, 1'b0, 0, 0, '0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, i, 0, 24'h4D4D4D);
    vs_low(35);
    chk_outs("refill", 24'h4D4D4D, 24'h4D4D4D, 24'h4D4D4D);
    set_roi(10, 5, 0, 15);
    step(1'b1, 1'b0, 0, 0, '0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, i, 0, 24'h4D4D4D);
    vs_low(35);
    chk_outs("x0_gt_x1", '0, '0, '0);

    // random frames, random ROI (possibly empty), random qualifier
    for (int f = 0; f < 6; f++) begin
      a = $urandom_range(15); b = $urandom_range(15);
      c = $urandom_range(15); d = $urandom_range(15);
      set_roi(a, b, c, d);
      step(1'b1, 1'b0, 0, 0, '0);
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++)
          step(1'b1, 1'($urandom_range(3) != 0), x, y, 24'($urandom));
      vs_low(35);
    end

    // 30 short frames: decimation on dut_b, overrun on dut_a
    do_reset();
    set_roi(0, 2047, 0, 2047);
    for (int k = 1; k <= 30; k++) begin
      step(1'b1, 1'b0, 0, 0, '0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i, 0, {8'(k), 8'(k), 8'(k)});
      vs_low(3);
    end
    vs_low(40);
    chk("decim_avg_b", 32'(avg_b), 32'h1E1E1E);
    chk("decim_min_b", 32'(min_b), 32'h1E1E1E);
    chk("overrun_a", 32'(ovr_a), 1);
    chk("overrun_b", 32'(ovr_b), 0);

    // reset while dividing
    step(1'b1, 1'b0, 0, 0, '0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, i, 0, 24'h323232);
    vs_low(10);
    chk("mid_div_busy", 32'(busy_a), 1);
    do_reset();
    vs_low(40);
    chk_outs("after_rst", '0, '0, '0);
    chk("after_rst_busy", 32'(busy_a), 0);

    chk("queue_empty", 32'(expq.size()), 0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
